mux_select_ctrl: RTL
====================

# mux_select_ctrl

Fault-tolerant channel-select controller that drives the select input of the 2:1 output multiplexer (A0 = primary channel, A1 = spare channel). Each cycle it parity-checks the word on the currently selected channel, filters transient errors with a consecutive-error counter, and switches the multiplexer select from primary to spare once the primary is judged permanently faulty. If the spare then also fails, it raises a sticky failure flag. It sits directly upstream of the mux and owns its select line.

## Interface
- W, 8: data width of each channel word.
- THRESH, 3: consecutive parity errors (≥2, ≤15) needed to declare the active channel faulty.
- CK  input  1  clock, rising edge.
- RN  input  1  reset; asynchronous, active-low.
- EN  input  1  sample qualifier; checks and counting happen only on cycles with EN=1.
- D0  input  W  primary channel word (same word that drives mux A0).
- P0  input  1  even-parity bit for D0.
- D1  input  W  spare channel word (same word that drives mux A1).
- P1  input  1  even-parity bit for D1.
- CLR  input  1  synchronous recovery request; honoured only in FAILED.
- SL  output  1  mux select; 0 = primary (A0), 1 = spare (A1). Registered.
- FAIL  output  1  sticky: both channels declared faulty. Registered.
- ERR  output  1  parity error on the active channel in the current cycle. Combinational, gated by EN.
- ECNT  output  4  current consecutive-error count. Registered.

## Operation
- Parity error on channel k: ^{Dk,Pk} == 1. The active channel is 0 in PRI and 1 in SPR.
- States: PRI (SL=0, FAIL=0), SPR (SL=1, FAIL=0), FAILED (SL=1, FAIL=1).
- In PRI or SPR, on a cycle with EN=1:
  - ERR=1 and ECNT+1 < THRESH: ECNT increments.
  - ERR=1 and ECNT+1 == THRESH: ECNT clears to 0. PRI moves to SPR; SPR moves to FAILED.
  - ERR=0: ECNT clears to 0. Errors must be consecutive among EN cycles.
- EN=0 cycles: ECNT, state and outputs hold. ERR=0. Non-EN cycles neither break nor extend a run.
- The inactive channel is never checked. The spare's parity during PRI has no effect.
- FAILED: ECNT holds at 0 and ERR still reports the channel-1 check. Only CLR=1 leaves this state: next state PRI, ECNT=0, FAIL=0. CLR is ignored in PRI and SPR.
- There is no automatic return from SPR to PRI.
- ECNT never exceeds THRESH-1.

## Timing
- Reset (RN=0, asynchronous): state PRI, SL=0, FAIL=0, ECNT=0 immediately, with no clock required.
- Reset asserted mid-run clears everything in the same instant.
- Reset is released synchronously by the user. The first edge with RN=1 is a normal cycle.
- Switch latency: if the THRESH-th consecutive error is sampled at edge n, SL (or FAIL) changes after edge n. The mux sees the new select one cycle after the failing word.
- ERR is combinational from D/P/EN and the current state, in the same cycle as the word.
- The first cycle after a PRI→SPR switch checks channel 1 with ECNT=0.
- Simultaneous CLR=1 and an error in FAILED: CLR wins. The next state is PRI with ECNT=0, and the error is not counted.
- When RN is high, all registers update only on the CK rising edge.

## Test plan
- Reset, clean data: RN low, then high. Drive EN=1, D0=8'hA5, P0=0 for 10 cycles. Required: SL=0, FAIL=0, ECNT=0 and ERR=0 throughout.
- Transient filter: drive two primary errors (D0=8'h01, P0=0), then one good word, then two more errors. Required: ECNT goes 1,2,0,1,2, and SL stays 0.
- Switchover: drive three consecutive primary errors. Required: ECNT goes 1,2 and then 0, with SL=1 after the third edge. Then drive 5 cycles of D1=8'h03, P1=0 with bad D0. Required: SL stays 1 and ERR=0.
- EN gating: drive error, EN=0 for 4 cycles with bad data, error, error. Required: SL rises only after the last error edge, and ECNT holds at 1 during the EN=0 cycles.
- Double fault and recovery: from SPR, drive three channel-1 errors. Required: FAIL=1 and SL=1. Then assert CLR=1 for one cycle while a channel-1 error is present. Required: next cycle SL=0, FAIL=0, ECNT=0.
- Async reset mid-run: with ECNT=2 in SPR, pulse RN low between clock edges. Required: SL=0, FAIL=0 and ECNT=0 before the next CK edge.

Source files
------------

// File: rtl/mux_select_ctrl_if.sv
// Channel words, parity, qualifiers and select/status outputs of the
// primary/spare channel-select controller.
interface mux_select_ctrl_if #(
  parameter int unsigned W = 8
);
  logic         EN;
  logic [W-1:0] D0;
  logic         P0;
  logic [W-1:0] D1;
  logic         P1;
  logic         CLR;
  logic         SL;
  logic         FAIL;
  logic         ERR;
  logic [3:0]   ECNT;

  modport master (
    output EN, D0, P0, D1, P1, CLR,
    input  SL, FAIL, ERR, ECNT
  );

  modport slave (
    input  EN, D0, P0, D1, P1, CLR,
    output SL, FAIL, ERR, ECNT
  );
endinterface

// File: rtl/mux_select_ctrl.sv
// Parity-checks the active channel, filters transient errors, and moves the
// 2:1 mux select from primary to spare, flagging failure if the spare dies too.
module mux_select_ctrl #(
  parameter int unsigned W      = 8,
  parameter int unsigned THRESH = 3
) (
  input logic              CK,
  input logic              RN,
  mux_select_ctrl_if.slave bus
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LAST_CNT = CW'(THRESH - 1);

  localparam logic [1:0] ST_PRI    = 2'b00;
  localparam logic [1:0] ST_SPR    = 2'b01;
  localparam logic [1:0] ST_FAILED = 2'b10;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] ecnt_q, ecnt_d;
  logic          sl_q, sl_d;
  logic          fail_q, fail_d;

  logic [W:0] word0, word1;
  logic       perr0, perr1, err_c;

  // Even parity over word plus parity bit; the spare is checked outside PRI.
  assign word0 = {bus.D0, bus.P0};
  assign word1 = {bus.D1, bus.P1};
  assign perr0 = ^word0;
  assign perr1 = ^word1;
  assign err_c = bus.EN & ((state_q == ST_PRI) ? perr0 : perr1);

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_PRI;
      ecnt_q  <= '0;
      sl_q    <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ecnt_q  <= ecnt_d;
      sl_q    <= sl_d;
      fail_q  <= fail_d;
    end
  end

  // Next-state: count consecutive errors among EN cycles, switch at THRESH.
  always_comb begin
    state_d = state_q;
    ecnt_d  = ecnt_q;
    case (state_q)
      ST_PRI, ST_SPR: begin
        if (bus.EN) begin
          if (err_c) begin
            if (ecnt_q == LAST_CNT) begin
              ecnt_d  = '0;
              state_d = (state_q == ST_PRI) ? ST_SPR : ST_FAILED;
            end else begin
              ecnt_d = ecnt_q + CW'(1);
            end
          end else begin
            ecnt_d = '0;
          end
        end
      end
      ST_FAILED: begin
        ecnt_d = '0;
        if (bus.CLR) begin
          state_d = ST_PRI;
        end
      end
      default: begin
        state_d = ST_PRI;
        ecnt_d  = '0;
      end
    endcase
    sl_d   = (state_d != ST_PRI);
    fail_d = (state_d == ST_FAILED);
  end

  assign bus.SL   = sl_q;
  assign bus.FAIL = fail_q;
  assign bus.ERR  = err_c;
  assign bus.ECNT = ecnt_q;

endmodule
